// File: rtl/mult8_product_accumulator_if.sv
// Product-in / result-out handshake bundle for mult8_product_accumulator.
interface mult8_product_accumulator_if #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
);
  logic             prod_valid;
  logic             prod_ready;
  logic [15:0]      prod_data;
  logic             prod_last;
  logic             acc_valid;
  logic             acc_ready;
  logic [ACC_W-1:0] acc_data;
  logic [CNT_W-1:0] acc_count;
  logic             acc_ovf;

  modport master (
    output prod_valid, prod_data, prod_last, acc_ready,
    input  prod_ready, acc_valid, acc_data, acc_count, acc_ovf
  );

  modport slave (
    input  prod_valid, prod_data, prod_last, acc_ready,
    output prod_ready, acc_valid, acc_data, acc_count, acc_ovf
  );
endinterface

// File: rtl/mult8_product_accumulator.sv
// Accumulates 16-bit products into one ACC_W-bit sum per frame, closed by last or FRAME_LEN beats.
// Build macro ACC_SATURATE_EN: clamp the frame sum at 2^ACC_W-1 instead of wrapping.
module mult8_product_accumulator #(
  parameter int ACC_W     = 24,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 8
) (
  input logic clk,
  input logic rst,
  mult8_product_accumulator_if.slave bus
);
  localparam logic [0:0]       ST_ACCUM    = 1'b0;
  localparam logic [0:0]       ST_HOLD     = 1'b1;
  localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]       state_q, state_d;
  logic             first_q, first_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] res_data_q, res_data_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic             res_ovf_q, res_ovf_d;

  logic             in_xfer_s;
  logic             out_xfer_s;
  logic             close_s;
  logic             carry_s;
  logic [ACC_W:0]   add_s;
  logic [ACC_W-1:0] beat_sum_s;
  logic [CNT_W-1:0] beat_cnt_s;
  logic             beat_ovf_s;

  assign bus.prod_ready = (state_q == ST_ACCUM);
  assign bus.acc_valid  = (state_q == ST_HOLD);
  assign bus.acc_data   = res_data_q;
  assign bus.acc_count  = res_cnt_q;
  assign bus.acc_ovf    = res_ovf_q;

  assign in_xfer_s  = bus.prod_valid && (state_q == ST_ACCUM);
  assign out_xfer_s = bus.acc_ready && (state_q == ST_HOLD);
  assign add_s      = {1'b0, sum_q} + {{(ACC_W-15){1'b0}}, bus.prod_data};
  assign carry_s    = add_s[ACC_W];
  assign close_s    = in_xfer_s && (bus.prod_last || (beat_cnt_s == FRAME_LEN_C));

  // Running totals after the current beat; the first beat of a frame reloads rather than adds.
  always_comb begin
    beat_sum_s = {ACC_W{1'b0}};
    beat_cnt_s = {CNT_W{1'b0}};
    beat_ovf_s = 1'b0;
    if (first_q) begin
      beat_sum_s = {{(ACC_W-16){1'b0}}, bus.prod_data};
      beat_cnt_s = CNT_ONE;
      beat_ovf_s = 1'b0;
    end else begin
      beat_cnt_s = cnt_q + CNT_ONE;
      beat_ovf_s = ovf_q | carry_s;
`ifdef ACC_SATURATE_EN
      beat_sum_s = carry_s ? {ACC_W{1'b1}} : add_s[ACC_W-1:0];
`else
      beat_sum_s = add_s[ACC_W-1:0];
`endif
    end
  end

  // Next state: accumulate in ACCUM, present the frame result in HOLD until taken.
  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    res_data_d = res_data_q;
    res_cnt_d  = res_cnt_q;
    res_ovf_d  = res_ovf_q;
    case (state_q)
      ST_ACCUM: begin
        if (in_xfer_s) begin
          sum_d   = beat_sum_s;
          cnt_d   = beat_cnt_s;
          ovf_d   = beat_ovf_s;
          first_d = 1'b0;
          if (close_s) begin
            state_d    = ST_HOLD;
            res_data_d = beat_sum_s;
            res_cnt_d  = beat_cnt_s;
            res_ovf_d  = beat_ovf_s;
            first_d    = 1'b1;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (out_xfer_s) begin
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  // State, running totals and held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ACCUM;
      first_q    <= 1'b1;
      sum_q      <= {ACC_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      ovf_q      <= 1'b0;
      res_data_q <= {ACC_W{1'b0}};
      res_cnt_q  <= {CNT_W{1'b0}};
      res_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      res_data_q <= res_data_d;
      res_cnt_q  <= res_cnt_d;
      res_ovf_q  <= res_ovf_d;
    end
  end
endmodule

// File: tb/tb_mult8_product_accumulator.sv
// Bench: four accumulator configurations checked every cycle against a frame-level model.
`timescale 1ns/1ps
module tb_mult8_product_accumulator;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]       pv, pl, ar, prdy, av, ao;
  logic [N-1:0][15:0] pd;
  logic [N-1:0][31:0] ad;
  logic [N-1:0][7:0]  ac;

  // Instance 0: defaults; 1: FRAME_LEN=3; 2: ACC_W=18; 3: FRAME_LEN=1.
  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int AW = (g == 2) ? 18 : 24;
    localparam int FL = (g == 1) ? 3 : ((g == 3) ? 1 : 16);
    mult8_product_accumulator_if #(.ACC_W(AW), .CNT_W(8)) bus ();
    assign bus.prod_valid = pv[g];
    assign bus.prod_data  = pd[g];
    assign bus.prod_last  = pl[g];
    assign bus.acc_ready  = ar[g];
    assign prdy[g]        = bus.prod_ready;
    assign av[g]          = bus.acc_valid;
    assign ad[g]          = 32'(bus.acc_data);
    assign ac[g]          = bus.acc_count;
    assign ao[g]          = bus.acc_ovf;
    mult8_product_accumulator #(.ACC_W(AW), .FRAME_LEN(FL), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .bus(bus)
    );
  end

  function automatic int aw_of(input int k);
    return (k == 2) ? 18 : 24;
  endfunction

  function automatic int fl_of(input int k);
    return (k == 1) ? 3 : ((k == 3) ? 1 : 16);
  endfunction

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  int cyc      = 0;

  task automatic check(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%0d required=%0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Frame-level model: unbounded running total, wrap/clamp applied once at frame close.
  longint tot[N];
  int     bc[N];
  bit     pend[N];
  longint e_data[N];
  int     e_cnt[N];
  bit     e_ovf[N];

  function automatic void close_frame(input int k);
    longint lim;
    lim      = (64'sd1 <<< aw_of(k)) - 64'sd1;
    e_ovf[k] = (tot[k] > lim);
`ifdef ACC_SATURATE_EN
    e_data[k] = e_ovf[k] ? lim : tot[k];
`else
    e_data[k] = tot[k] % (lim + 64'sd1);
`endif
    e_cnt[k] = bc[k];
    tot[k]   = 0;
    bc[k]    = 0;
    pend[k]  = 1'b1;
  endfunction

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        tot[k] = 0; bc[k] = 0; pend[k] = 1'b0;
        e_data[k] = 0; e_cnt[k] = 0; e_ovf[k] = 1'b0;
      end else if (pend[k]) begin
        if (ar[k] === 1'b1) pend[k] = 1'b0;
      end else if (pv[k] === 1'b1) begin
        tot[k] += longint'(pd[k]);
        bc[k]++;
        if (pl[k] === 1'b1 || bc[k] == fl_of(k)) close_frame(k);
      end
    end
  end

  // Per-cycle compare against the model, plus a log of each new result beat.
  int           nres[N] = '{default: 0};
  logic [31:0]  rlog_d[N][4];
  logic [7:0]   rlog_c[N][4];
  logic [N-1:0] av_prev = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < N; k++) begin
        check("prod_ready", k, 64'(prdy[k]), 64'(!pend[k]));
        check("acc_valid",  k, 64'(av[k]),   64'(pend[k]));
        check("acc_data",   k, 64'(ad[k]),   64'(e_data[k]));
        check("acc_count",  k, 64'(ac[k]),   64'(e_cnt[k]));
        check("acc_ovf",    k, 64'(ao[k]),   64'(e_ovf[k]));
        if (av[k] === 1'b1 && av_prev[k] !== 1'b1 && nres[k] < 4) begin
          rlog_d[k][nres[k]] = ad[k];
          rlog_c[k][nres[k]] = ac[k];
          nres[k]++;
        end
        av_prev[k] = av[k];
      end
    end
  end

  int acc_cyc[N];

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input int k, input logic [15:0] d, input logic last);
    int n;
    n = 0;
    pv[k] = 1'b1; pd[k] = d; pl[k] = last;
    while (prdy[k] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++; failures++;
      $display("FAIL send_timeout[%0d] actual=no_ready required=ready", k);
    end
    acc_cyc[k] = cyc;
    @(negedge clk);
    pv[k] = 1'b0; pd[k] = 'x; pl[k] = 'x;
  endtask

  task automatic reset_literals(input int k);
    check("rst_prod_ready", k, 64'(prdy[k]), 64'd1);
    check("rst_acc_valid",  k, 64'(av[k]),   64'd0);
    check("rst_acc_data",   k, 64'(ad[k]),   64'd0);
    check("rst_acc_count",  k, 64'(ac[k]),   64'd0);
    check("rst_acc_ovf",    k, 64'(ao[k]),   64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int low;
    pv = '0; pl = '0; pd = '0; ar = '1; rst = 1'b1;
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset_literals(0);
    rst = 1'b0;

    // 1: four 255*255 beats, last on the fourth.
    for (int i = 0; i < 4; i++) send(0, 16'd65025, (i == 3));
    check("t1_valid", 0, 64'(av[0]), 64'd1);
    check("t1_data",  0, 64'(ad[0]), 64'd260100);
    check("t1_count", 0, 64'(ac[0]), 64'd4);
    check("t1_ovf",   0, 64'(ao[0]), 64'd0);
    low = 0;
    for (int i = 0; i < 4; i++) begin
      if (prdy[0] === 1'b0) low++;
      @(negedge clk);
    end
    check("t1_ready_low_cycles", 0, 64'(low), 64'd1);

    // 2: FRAME_LEN=3 auto-close, beats 1..6.
    for (int i = 1; i <= 6; i++) send(1, 16'(i), 1'b0);
    @(negedge clk);
    check("t2_nres",   1, 64'(nres[1]),      64'd2);
    check("t2_data0",  1, 64'(rlog_d[1][0]), 64'd6);
    check("t2_count0", 1, 64'(rlog_c[1][0]), 64'd3);
    check("t2_data1",  1, 64'(rlog_d[1][1]), 64'd15);
    check("t2_count1", 1, 64'(rlog_c[1][1]), 64'd3);

    // 3: ACC_W=18 overflow with five 65025 beats.
    for (int i = 0; i < 5; i++) send(2, 16'd65025, (i == 4));
    check("t3_count", 2, 64'(ac[2]), 64'd5);
    check("t3_ovf",   2, 64'(ao[2]), 64'd1);
`ifdef ACC_SATURATE_EN
    check("t3_data",  2, 64'(ad[2]), 64'd262143);
`else
    check("t3_data",  2, 64'(ad[2]), 64'd62981);
`endif
    @(negedge clk);

    // 4: backpressure with valid toggling during HOLD, then a fresh frame.
    ar[0] = 1'b0;
    send(0, 16'd10, 1'b0);
    send(0, 16'd20, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 0, 64'(av[0]),   64'd1);
      check("t4_hold_data",  0, 64'(ad[0]),   64'd30);
      check("t4_hold_ready", 0, 64'(prdy[0]), 64'd0);
      pv[0] = (i % 2 == 0); pd[0] = 16'd999; pl[0] = 1'b1;
      @(negedge clk);
    end
    pv[0] = 1'b0; pd[0] = 'x; pl[0] = 'x;
    ar[0] = 1'b1;
    @(negedge clk);
    check("t4_valid_drop", 0, 64'(av[0]),   64'd0);
    check("t4_ready_back", 0, 64'(prdy[0]), 64'd1);
    send(0, 16'd5, 1'b1);
    check("t4_fresh_data",  0, 64'(ad[0]), 64'd5);
    check("t4_fresh_count", 0, 64'(ac[0]), 64'd1);
    @(negedge clk);

    // 5: reset mid-frame, then beats 7 and 9.
    send(0, 16'd1000, 1'b0);
    send(0, 16'd2000, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    reset_literals(0);
    rst = 1'b0;
    send(0, 16'd7, 1'b0);
    send(0, 16'd9, 1'b1);
    check("t5_data",  0, 64'(ad[0]), 64'd16);
    check("t5_count", 0, 64'(ac[0]), 64'd2);
    check("t5_ovf",   0, 64'(ao[0]), 64'd0);
    @(negedge clk);

    // 6: FRAME_LEN=1, back-to-back beats.
    send(3, 16'd100, 1'b0);
    low = acc_cyc[3];
    send(3, 16'd200, 1'b0);
    check("t6_accept_gap", 3, 64'(acc_cyc[3] - low), 64'd2);
    @(negedge clk);
    check("t6_nres",   3, 64'(nres[3]),      64'd2);
    check("t6_data0",  3, 64'(rlog_d[3][0]), 64'd100);
    check("t6_count0", 3, 64'(rlog_c[3][0]), 64'd1);
    check("t6_data1",  3, 64'(rlog_d[3][1]), 64'd200);
    check("t6_count1", 3, 64'(rlog_c[3][1]), 64'd1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
